// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-high patterns ordered {g,f,e,d,c,b,a}
// and the width of one BCD digit.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_counter_display_bcd_to_seg.sv
// Single BCD digit to seven-segment decoder; codes above 9 blank the digit.
module bcd_to_seg
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    logic [6:0] pattern;

    // Look up the active-high pattern, then apply the board polarity.
    always_comb begin
        pattern = SEG_BLANK;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        seg = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaled tick, parallel load, registered
// wrap pulse and per-digit seven-segment decode.
module bcd_counter_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned PRESCALE       = 1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        master_reset,
    input  logic                        enable,
    input  logic                        up_down,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic [7*NUM_DIGITS-1:0]     seg,
    output logic                        indicator
);

    localparam int unsigned CW = BCD_W * NUM_DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       pcnt;
    logic                tick;
    logic [CW-1:0]       inc_val;
    logic [CW-1:0]       dec_val;
    logic [CW-1:0]       sat_val;
    logic [NUM_DIGITS:0] carry;
    logic [NUM_DIGITS:0] borrow;

    assign tick      = enable && (pcnt == PLAST);
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Both the incremented and decremented values are built every cycle; the
    // final carry/borrow out of the top digit is the wrap condition.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] d;
        logic [BCD_W-1:0] ld;

        assign d  = count_bcd[i*BCD_W +: BCD_W];
        assign ld = load_value[i*BCD_W +: BCD_W];

        assign inc_val[i*BCD_W +: BCD_W] = !carry[i]  ? d : ((d >= 4'd9) ? 4'd0 : d + 4'd1);
        assign carry[i+1]                = carry[i] && (d >= 4'd9);
        assign dec_val[i*BCD_W +: BCD_W] = !borrow[i] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
        assign borrow[i+1]               = borrow[i] && (d == 4'd0);
        assign sat_val[i*BCD_W +: BCD_W] = (ld > 4'd9) ? 4'd9 : ld;

        bcd_to_seg #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_dec (
            .bcd(d),
            .seg(seg[i*7 +: 7])
        );
    end

    // Count, prescaler and wrap pulse: reset > load > tick > hold.
    always_ff @(posedge clk) begin
        if (master_reset) begin
            count_bcd <= '0;
            pcnt      <= '0;
            indicator <= 1'b0;
        end else if (load) begin
            count_bcd <= sat_val;
            pcnt      <= '0;
            indicator <= 1'b0;
        end else begin
            indicator <= 1'b0;
            if (enable) begin
                pcnt <= tick ? '0 : pcnt + PW'(1);
            end
            if (tick) begin
                count_bcd <= up_down ? inc_val : dec_val;
                indicator <= up_down ? carry[NUM_DIGITS] : borrow[NUM_DIGITS];
            end
        end
    end

endmodule
